// File: rtl/prim_stim_gen.sv
// Phased stimulus sequencer for flip-flop primitive benches: reset hold, load,
// hold and mixed-random phases, driven from a seeded 16-bit Fibonacci LFSR.
module prim_stim_gen #(
  parameter int          WIDTH    = 1,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          RST_CYC  = 2,
  parameter int          LOAD_CYC = 10,
  parameter int          HOLD_CYC = 4,
  parameter int          MIX_CYC  = 32,
  parameter bit          MID_RST  = 1'b1
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  output logic [WIDTH-1:0] D_out,
  output logic             E_out,
  output logic             R_out,
  output logic             busy,
  output logic             done,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RESET_PH = 3'd1,
    LOAD     = 3'd2,
    HOLD     = 3'd3,
    MIXED    = 3'd4,
    DONE     = 3'd5
  } phase_e;

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] RST_LAST  = 16'(RST_CYC - 1);
  localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYC - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
  localparam logic [15:0] MIX_LAST  = 16'(MIX_CYC - 1);

  phase_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_next;
  logic        busy_d, e_d, r_d;

  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign phase     = state_q;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RESET_PH;
          cnt_d   = RST_LAST;
        end
      end
      RESET_PH: begin
        if (cnt_q == 16'd0) begin
          state_d = LOAD;
          cnt_d   = LOAD_LAST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      LOAD: begin
        if (cnt_q == 16'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LAST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = MIXED;
          cnt_d   = MIX_LAST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      MIXED: begin
        if (cnt_q == 16'd0) begin
          state_d = DONE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the phase about to be entered
  // and from the LFSR value that is consumed on that same edge.
  always_comb begin
    busy_d = 1'b0;
    e_d    = 1'b0;
    r_d    = 1'b1;
    case (state_d)
      IDLE:     r_d = 1'b0;
      RESET_PH: begin busy_d = 1'b1; r_d = 1'b0; end
      LOAD:     begin busy_d = 1'b1; e_d = 1'b1; end
      HOLD:     busy_d = 1'b1;
      MIXED: begin
        busy_d = 1'b1;
        e_d    = lfsr_q[15];
        r_d    = !(MID_RST && (lfsr_q[14:12] == 3'b111));
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      lfsr_q  <= SEED_EFF;
      D_out   <= '0;
      E_out   <= 1'b0;
      R_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      E_out   <= e_d;
      R_out   <= r_d;
      busy    <= busy_d;
      done    <= (state_d == DONE);
      if (busy_d) begin
        D_out  <= lfsr_q[WIDTH-1:0];
        lfsr_q <= lfsr_next;
      end
    end
  end

endmodule

// File: tb/tb_prim_stim_gen.sv
// Scoreboard bench for prim_stim_gen: four parameterisations share clock, reset
// and start; expected per-cycle outputs are queued at start and popped by monitors.
module tb_prim_stim_gen;

  typedef struct packed {
    logic [2:0]  ph;
    logic [15:0] d;
    logic        e;
    logic        r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]  d_a, d_b;
  logic [7:0]  d_c;
  logic [15:0] d_d;
  logic        e_a, e_b, e_c, e_d, r_a, r_b, r_c, r_d;
  logic        busy_a, busy_b, busy_c, busy_d, done_a, done_b, done_c, done_d;
  logic [2:0]  ph_a, ph_b, ph_c, ph_d;

  prim_stim_gen #(.WIDTH(4), .SEED(16'hACE1), .RST_CYC(2), .LOAD_CYC(10), .HOLD_CYC(4),
                  .MIX_CYC(32), .MID_RST(1'b1)) u_a (
    .C(clk), .R(rst_n), .start(start), .D_out(d_a), .E_out(e_a), .R_out(r_a),
    .busy(busy_a), .done(done_a), .phase(ph_a));

  prim_stim_gen #(.WIDTH(4), .SEED(16'h0000), .RST_CYC(2), .LOAD_CYC(10), .HOLD_CYC(4),
                  .MIX_CYC(32), .MID_RST(1'b1)) u_b (
    .C(clk), .R(rst_n), .start(start), .D_out(d_b), .E_out(e_b), .R_out(r_b),
    .busy(busy_b), .done(done_b), .phase(ph_b));

  prim_stim_gen #(.WIDTH(8), .SEED(16'h1234), .RST_CYC(1), .LOAD_CYC(1), .HOLD_CYC(1),
                  .MIX_CYC(200), .MID_RST(1'b0)) u_c (
    .C(clk), .R(rst_n), .start(start), .D_out(d_c), .E_out(e_c), .R_out(r_c),
    .busy(busy_c), .done(done_c), .phase(ph_c));

  prim_stim_gen #(.WIDTH(16), .SEED(16'hBEEF), .RST_CYC(2), .LOAD_CYC(10), .HOLD_CYC(4),
                  .MIX_CYC(200), .MID_RST(1'b1)) u_d (
    .C(clk), .R(rst_n), .start(start), .D_out(d_d), .E_out(e_d), .R_out(r_d),
    .busy(busy_d), .done(done_d), .phase(ph_d));

  // Reference model parameters; instance b expects the substitute seed.
  int          p_w    [4] = '{4, 4, 8, 16};
  logic [15:0] p_seed [4] = '{16'hACE1, 16'hACE1, 16'h1234, 16'hBEEF};
  int          p_rst  [4] = '{2, 2, 1, 2};
  int          p_load [4] = '{10, 10, 1, 10};
  int          p_hold [4] = '{4, 4, 1, 4};
  int          p_mix  [4] = '{32, 32, 200, 200};
  bit          p_mid  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  int          tot    [4] = '{48, 48, 203, 216};

  exp_t        sb [4][$];
  logic [15:0] mlfsr  [4];
  logic [15:0] last_d [4];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic push_run(input int i);
    exp_t        x;
    logic [15:0] l;
    logic [31:0] mask;
    mask = (32'd1 << p_w[i]) - 32'd1;
    for (int c = 0; c < tot[i]; c++) begin
      l = mlfsr[i];
      if (c < p_rst[i])                           x.ph = 3'd1;
      else if (c < p_rst[i] + p_load[i])          x.ph = 3'd2;
      else if (c < p_rst[i] + p_load[i] + p_hold[i]) x.ph = 3'd3;
      else                                        x.ph = 3'd4;
      x.d = l & mask[15:0];
      x.e = (x.ph == 3'd2) ? 1'b1 : (x.ph == 3'd4) ? l[15] : 1'b0;
      x.r = (x.ph == 3'd1) ? 1'b0 :
            ((x.ph == 3'd4) && p_mid[i] && (l[14:12] == 3'b111)) ? 1'b0 : 1'b1;
      sb[i].push_back(x);
      mlfsr[i] = adv(l);
    end
  endtask

  task automatic mon(input int i, input logic bz, input logic [2:0] ph, input logic [15:0] d,
                     input logic e, input logic r);
    exp_t x;
    if (!bz) return;
    if (sb[i].size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb%0d_underflow: busy=1 with no expected cycle queued", i);
      return;
    end
    x = sb[i].pop_front();
    check($sformatf("sb%0d_phase", i), 32'(ph), 32'(x.ph));
    check($sformatf("sb%0d_d_out", i), 32'(d), 32'(x.d));
    check($sformatf("sb%0d_e_out", i), 32'(e), 32'(x.e));
    check($sformatf("sb%0d_r_out", i), 32'(r), 32'(x.r));
    last_d[i] = x.d;
  endtask

  always @(negedge clk) mon(0, busy_a, ph_a, 16'(d_a), e_a, r_a);
  always @(negedge clk) mon(1, busy_b, ph_b, 16'(d_b), e_b, r_b);
  always @(negedge clk) mon(2, busy_c, ph_c, 16'(d_c), e_c, r_c);
  always @(negedge clk) mon(3, busy_d, ph_d, d_d, e_d, r_d);

  task automatic check_idle(input string tag);
    check({tag, "_a_phase"}, 32'(ph_a), 0);
    check({tag, "_a_d"},     32'(d_a), 0);
    check({tag, "_a_e"},     32'(e_a), 0);
    check({tag, "_a_r"},     32'(r_a), 0);
    check({tag, "_a_busy"},  32'(busy_a), 0);
    check({tag, "_a_done"},  32'(done_a), 0);
    check({tag, "_b_d"},     32'(d_b), 0);
    check({tag, "_c_phase"}, 32'(ph_c), 0);
    check({tag, "_c_r"},     32'(r_c), 0);
    check({tag, "_d_d"},     32'(d_d), 0);
    check({tag, "_d_busy"},  32'(busy_d), 0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_idle(tag);
    for (int i = 0; i < 4; i++) begin
      sb[i].delete();
      mlfsr[i] = p_seed[i];
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input bit fresh, input int abort_at);
    int   k;
    int   first_done [4];
    logic [3:0] dn;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_run(i);
      first_done[i] = -1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (fresh) begin
      check("first_d_a", 32'(d_a), 32'h1);
      check("first_d_b", 32'(d_b), 32'h1);
    end
    k = 0;
    while (k < 300 && (first_done[0] < 0 || first_done[1] < 0 ||
                       first_done[2] < 0 || first_done[3] < 0)) begin
      @(posedge clk);
      #1;
      k++;
      if (fresh && k == 1) begin
        check("second_d_a", 32'(d_a), 32'h3);
        check("second_d_b", 32'(d_b), 32'h3);
      end
      if (k == abort_at) begin
        check("abort_in_load", 32'(ph_a), 32'd2);
        apply_reset("abort");
        return;
      end
      start = (k == 20);
      dn = {done_d, done_c, done_b, done_a};
      for (int i = 0; i < 4; i++)
        if (first_done[i] < 0 && dn[i]) first_done[i] = k;
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("done_latency_%0d", i), 32'(first_done[i]), 32'(tot[i]));
      check($sformatf("sb%0d_leftover", i), 32'(sb[i].size()), 0);
    end
    @(posedge clk);
    #1;
    check("done_phase_a", 32'(ph_a), 32'd5);
    check("done_r_a",     32'(r_a), 1);
    check("done_e_a",     32'(e_a), 0);
    check("done_busy_a",  32'(busy_a), 0);
    check("done_flag_a",  32'(done_a), 1);
    check("done_hold_d_a", 32'(d_a), 32'(last_d[0]));
    check("done_hold_d_d", 32'(d_d), 32'(last_d[3]));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mlfsr[i]  = p_seed[i];
      last_d[i] = '0;
    end
    #1;
    check_idle("in_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_idle("idle_hold");

    run(1'b1, -1);  // fresh run, with a start pulse while busy
    run(1'b0, -1);  // restart from DONE, LFSR continues
    run(1'b0, 6);   // abort in the fifth LOAD cycle
    run(1'b1, -1);  // replay after reset must repeat the seeded sequence

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
